mem_port_arbiter: RTL

Arbitrates the CPU's single shared memory port between the instruction-fetch requester (IFetch stage) and the data requester (Memory stage). It latches one transaction at a time, drives the memory with a valid/ready handshake, returns read data and a one-cycle completion pulse to the winning requester, and aborts hung accesses with a timeout. It sits between the CPU control FSM and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port arbiter.
// Carries both requester channels (fetch and data) and the memory-side
// valid/ready handshake. The arbiter uses the slave view; the CPU and
// memory model side uses the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;

    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic [1:0]    grant;
    logic          err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done,
               mem_valid, mem_we, mem_addr, mem_wdata, grant, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done,
               mem_valid, mem_we, mem_addr, mem_wdata, grant, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter between the instruction-fetch and data
// requesters. One transaction at a time: IDLE picks a winner (round-robin
// on contention), BUSY holds the access on the memory bus until mem_ready
// or a timeout, RESP pulses done to the winner for one cycle.
// Every output comes straight from a flop.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input logic            clk,
    input logic            reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IF   = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;
    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);

    state_t        state_q, state_d;
    logic          last_data_q, last_data_d;
    logic [1:0]    grant_q, grant_d;
    logic          err_q, err_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic          pick_data;
    logic          finish;
    logic [DW-1:0] resp_data;

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        grant_d     = grant_q;
        err_d       = err_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        pick_data   = 1'b0;
        finish      = 1'b0;
        resp_data   = '0;

        case (state_q)
            IDLE: begin
                // Data wins when it is alone, or on contention when fetch went last.
                pick_data = bus.d_req && (!bus.if_req || !last_data_q);
                if (bus.if_req || bus.d_req) begin
                    if (pick_data) begin
                        grant_d     = GRANT_D;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        last_data_d = 1'b1;
                    end else begin
                        grant_d     = GRANT_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        last_data_d = 1'b0;
                    end
                    err_d       = 1'b0;
                    mem_valid_d = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // mem_ready takes priority over a timeout landing in the same cycle.
                finish    = bus.mem_ready || (wait_cnt_q == WAIT_LAST);
                resp_data = bus.mem_ready ? bus.mem_rdata : '0;
                if (finish) begin
                    err_d       = !bus.mem_ready;
                    mem_valid_d = 1'b0;
                    state_d     = RESP;
                    if (grant_q == GRANT_D) begin
                        d_done_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = resp_data;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = resp_data;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                grant_d = GRANT_NONE;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            grant_q     <= GRANT_NONE;
            err_q       <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wait_cnt_q  <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            grant_q     <= grant_d;
            err_q       <= err_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.grant     = grant_q;
    assign bus.err       = err_q;

endmodule
